// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, round-constant seed, FSM state
// type and column-major byte addressing of a 128-bit state word.
package aes_pkg;

  localparam logic [7:0] RCON_RESET = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } aes_state_t;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Byte n of the state (n = 4*col + row) lives at bits [127-8n -: 8].
  function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
    return 4 * col + row;
  endfunction

  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return 8 * (15 - byte_idx(row, col));
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned row,
                                          input int unsigned col);
    return s[byte_lsb(row, col) +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to each byte of a 32-bit word.
module aes_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Four independent byte lookups.
  always_comb begin
    sub_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sub_word[8*i +: 8] = SBOX[word[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_encipher.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded
// on the fly from the previous round key.
module aes_encipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] block,
  output logic         ready,
  output logic         result_valid,
  output logic [127:0] result
);

  aes_state_t   fsm;
  logic [127:0] state;
  logic [127:0] rk;
  logic [7:0]   rcon;
  logic [3:0]   round;

  logic [31:0]  col_sub [4];
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [31:0]  key_sub;
  logic [31:0]  t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_rk;

  // SubBytes: one S-box per state column.
  for (genvar c = 0; c < 4; c++) begin : g_col_sbox
    aes_sbox u_sbox (
      .word     (state[32*(3-c) +: 32]),
      .sub_word (col_sub[c])
    );
  end

  // SubWord(RotWord(w3)) for the key schedule.
  aes_sbox u_key_sbox (
    .word     ({rk[23:0], rk[31:24]}),
    .sub_word (key_sub)
  );

  assign t_word  = key_sub ^ {rcon, 24'h0};
  assign w0_n    = rk[127:96] ^ t_word;
  assign w1_n    = rk[95:64]  ^ w0_n;
  assign w2_n    = rk[63:32]  ^ w1_n;
  assign w3_n    = rk[31:0]   ^ w2_n;
  assign next_rk = {w0_n, w1_n, w2_n, w3_n};

  // Reassemble the substituted columns into a state word.
  always_comb begin
    sb = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      sb[32*(3-c) +: 32] = col_sub[c];
    end
  end

  // ShiftRows: row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[byte_lsb(r, c) +: 8] = get_byte(sb, r, (c + r) % 4);
      end
    end
  end

  // MixColumns: each output byte is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
  always_comb begin
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        mc[byte_lsb(r, c) +: 8] = gmul2(get_byte(sr, r, c))
                                ^ gmul3(get_byte(sr, (r + 1) % 4, c))
                                ^ get_byte(sr, (r + 2) % 4, c)
                                ^ get_byte(sr, (r + 3) % 4, c);
      end
    end
  end

  // Control FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= IDLE;
      state        <= '0;
      rk           <= '0;
      rcon         <= RCON_RESET;
      round        <= '0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start) begin
            state <= block ^ key;
            rk    <= key;
            rcon  <= RCON_RESET;
            round <= 4'd1;
            ready <= 1'b0;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          state <= mc ^ next_rk;
          rk    <= next_rk;
          rcon  <= xtime(rcon);
          round <= round + 4'd1;
          if (round == 4'd9) begin
            fsm <= FINAL;
          end
        end
        FINAL: begin
          state        <= sr ^ next_rk;
          rk           <= next_rk;
          rcon         <= xtime(rcon);
          round        <= round + 4'd1;
          result       <= sr ^ next_rk;
          result_valid <= 1'b1;
          ready        <= 1'b1;
          fsm          <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher.sv
// Bench for aes_encipher against an independent byte-array AES-128 model.
module tb_aes_encipher;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] block;
  logic         ready;
  logic         result_valid;
  logic [127:0] result;

  int vectors;
  int miscompares;

  logic [7:0] sb_tab [256];

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BRK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encipher dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .block        (block),
    .ready        (ready),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box built from the multiplicative inverse and the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] x8;
    for (int x = 0; x < 256; x++) begin
      x8  = x[7:0];
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gf_mul(x8, y[7:0]) == 8'h01) inv = y[7:0];
        end
      end
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic aes_model(input logic [127:0] k, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] lastk);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a [4];
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) begin
      s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) s[j] = sb_tab[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[r+4*c];
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r+4*c] = gf_mul(8'h02, a[r]) ^ gf_mul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
          else
            s[r+4*c] = a[r];
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
    lastk = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one job and wait (bounded) for its result pulse. lat = edges after capture.
  task automatic run_job(input logic [127:0] k, input logic [127:0] b,
                         output logic [127:0] res, output int lat);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    block = b;
    @(negedge clk);
    start = 1'b0;
    key   = rand128();
    block = rand128();
    lat   = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    res = result;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    block = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", result_valid);
    end
    vectors++;
    if (result !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    vectors++;
    if (dut.rcon !== 8'h01 || dut.rk !== 128'h0 || dut.state !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_regs: rcon %h rk %h state %h want 01/0/0", dut.rcon, dut.rk, dut.state);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: ready %b valid %b want 1/0", ready, result_valid);
    end
  endtask

  task automatic test_fips_c1();
    logic [127:0] res, exp, lk;
    int lat;
    aes_model(C1K, C1P, exp, lk);
    run_job(C1K, C1P, res, lat);
    vectors++;
    if (lat != 10) begin
      miscompares++;
      $display("FAIL c1_latency: got %0d want 10", lat);
    end
    vectors++;
    if (res !== C1C) begin
      miscompares++;
      $display("FAIL c1_result: got %h want %h", res, C1C);
    end
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL c1_model: got %h want %h", res, exp);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL c1_ready_with_valid: got %b want 1", ready);
    end
  endtask

  task automatic test_fips_b();
    logic [127:0] res;
    int lat;
    run_job(BK, BP, res, lat);
    vectors++;
    if (lat != 10 || res !== BC) begin
      miscompares++;
      $display("FAIL b_result: got %h lat %0d want %h lat 10", res, lat, BC);
    end
    vectors++;
    if (dut.rk !== BRK) begin
      miscompares++;
      $display("FAIL b_last_rk: got %h want %h", dut.rk, BRK);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] r1;
    int lat;
    int seen;
    run_job(128'h0, 128'h0, r1, lat);
    vectors++;
    if (lat != 10 || r1 !== ZC) begin
      miscompares++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat 10", r1, lat, ZC);
    end
    // Still in the result_valid cycle: launch the next job immediately.
    start = 1'b1;
    key   = C1K;
    block = C1P;
    @(negedge clk);
    start = 1'b0;
    key   = rand128();
    block = rand128();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: ready got %b want 0", ready);
    end
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) begin
        vectors++;
        if (result !== ZC || result_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_hold cycle %0d: result %h valid %b want %h/0", i, result, result_valid, ZC);
        end
      end else begin
        seen = 1;
        vectors++;
        if (result_valid !== 1'b1 || result !== C1C) begin
          miscompares++;
          $display("FAIL b2b_second: result %h valid %b want %h/1", result, result_valid, C1C);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0 || seen != 1) begin
      miscompares++;
      $display("FAIL b2b_pulse_width: valid %b want 0", result_valid);
    end
  endtask

  task automatic test_ignore_start();
    logic [127:0] k, b, exp, lk;
    int lat;
    k = rand128();
    b = rand128();
    aes_model(k, b, exp, lk);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    block = b;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (result_valid) begin
        lat = i;
        break;
      end
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_ready cycle %0d: got %b want 0", i, ready);
      end
      if (i == 2 || i == 6) begin
        start = 1'b1;
        key   = rand128();
        block = rand128();
      end
    end
    vectors++;
    if (lat != 10 || result !== exp) begin
      miscompares++;
      $display("FAIL ignore_result: got %h lat %0d want %h lat 10", result, lat, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    int pulses;
    @(negedge clk);
    start = 1'b1;
    key   = BK;
    block = BP;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || result !== 128'h0) begin
      miscompares++;
      $display("FAIL midreset_async: ready %b valid %b result %h want 1/0/0", ready, result_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    vectors++;
    if (pulses != 0 || ready !== 1'b1 || result !== 128'h0) begin
      miscompares++;
      $display("FAIL midreset_no_pulse: pulses %0d ready %b result %h want 0/1/0", pulses, ready, result);
    end
    run_job(BK, BP, res, lat);
    vectors++;
    if (lat != 10 || res !== BC) begin
      miscompares++;
      $display("FAIL midreset_fresh: got %h lat %0d want %h lat 10", res, lat, BC);
    end
  endtask

  task automatic test_random();
    logic [127:0] k, b, exp, lk, res;
    int lat;
    for (int n = 0; n < 8; n++) begin
      k = rand128();
      b = rand128();
      aes_model(k, b, exp, lk);
      run_job(k, b, res, lat);
      vectors++;
      if (lat != 10 || res !== exp) begin
        miscompares++;
        $display("FAIL random_%0d: got %h lat %0d want %h lat 10", n, res, lat, exp);
      end
      vectors++;
      if (dut.rk !== lk) begin
        miscompares++;
        $display("FAIL random_rk_%0d: got %h want %h", n, dut.rk, lk);
      end
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b0 || result !== exp) begin
        miscompares++;
        $display("FAIL random_hold_%0d: valid %b result %h want 0/%h", n, result_valid, result, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    block = '0;
    init_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_encipher.md
# aes_encipher

Iterative AES-128 encryption core and forward counterpart of the decryption datapath's inverse S-box. It accepts one 128-bit plaintext block and one 128-bit key, then performs one AES round per clock. Round keys are expanded on the fly, with no key memory. It sits beside the decipher core in the `aes` block and shares its byte ordering and package.

## Interface
- Parameters: none. Nr = 10 and Nk = 4 are fixed; AES-192/256 are out of scope.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready` = 1.
- `key`  in  128  cipher key, sampled with `start`; `key[127:120]` is key byte 0.
- `block`  in  128  plaintext, sampled with `start`; `block[127:120]` is state byte s0 (row 0, col 0), column-major per FIPS-197.
- `ready`  out  1  high when idle and able to accept `start`.
- `result_valid`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  128  ciphertext, same byte order as `block`; held until the next completion.

## Operation
- Datapath registers:
  - 128-bit `state`.
  - 128-bit `rk` (current round key).
  - 8-bit `rcon`.
  - 4-bit `round` counter.
- FSM states: IDLE, ROUND, FINAL.
- IDLE, with `ready` = 1. On `start`:
  - `state` <= `block` ^ `key`
  - `rk` <= `key`
  - `rcon` <= 8'h01
  - `round` <= 1
  - go to ROUND.
- ROUND (rounds 1..9):
  - next_rk = expand(`rk`, `rcon`), computed combinationally.
  - `state` <= MixColumns(ShiftRows(SubBytes(`state`))) ^ next_rk.
  - `rk` <= next_rk; `rcon` <= xtime(`rcon`); `round` += 1.
  - When `round` = 9, go to FINAL.
- FINAL (round 10): same as ROUND but MixColumns is omitted.
  - `result` <= computed value; `result_valid` <= 1; go to IDLE.
- expand():
  - t = SubWord(RotWord(w3)) ^ {`rcon`, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - words are w0 = `rk[127:96]` through w3 = `rk[31:0]`.
- Round constant: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). The sequence is 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses GF(2^8) multiplication by 2 and 3 only, built from xtime and XOR. Modulus is 0x11b.
- `start` while `ready` = 0 is ignored; there is no queueing.
- `key` and `block` may change freely after the capture cycle.

## Timing
- Reset values:
  - `ready` = 1, `result_valid` = 0, `result` = 0.
  - `state`, `rk`, `round` = 0; `rcon` = 8'h01; FSM in IDLE.
- Capture happens at edge E0, where `start` & `ready`. `ready` drops after E0.
- Rounds 1..10 complete at edges E1..E10.
- `result_valid` and `ready` are both high in the cycle after E10. Latency is 10 cycles from the capture edge to valid; throughput is one block per 11 cycles.
- Back-to-back: `start` in the `result_valid` cycle is accepted, since `ready` = 1. `result` then holds until that next job's E10.
- `result_valid` is a pulse. It is never high for two consecutive cycles.
- Reset asserted mid-operation aborts the job immediately. All outputs return to reset values and no `result_valid` is produced.
- Critical path, single cycle: SubBytes, ShiftRows, MixColumns, and an XOR with the key path (SubWord plus the 4-word XOR chain). No pipelining inside the round.

## Structure
- `aes_pkg` holds:
  - the xtime / gmul2 / gmul3 functions
  - the rcon reset constant 8'h01
  - the FSM state typedef (IDLE, ROUND, FINAL)
  - the byte-index helpers for column-major order.
- `aes_pkg` is shared with the decipher core, which adds its inverse helpers.
- Sub-module `aes_sbox`: combinational forward S-box with 32-bit word in and out, four byte lookups. Instantiate it 5 times: 4 for state columns, 1 for key expansion SubWord.
- ShiftRows, MixColumns and AddRoundKey stay inline in `aes_encipher`.

## Test plan
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> `result` 69c4e0d86a7b0430d8cdb78070b4c55a. `result_valid` must appear exactly 10 cycles after the capture edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
  - Probe internal `rk` after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and block -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then issue `start` in the `result_valid` cycle with the C.1 vectors. The second result must be correct, and the first must hold until the second job's E10.
- Pulse `start` with other data during rounds 3 and 7 of a job -> ignored. The in-flight result is unchanged and `ready` stays 0 until completion.
- Assert `rst` at round 5:
  - Outputs return to reset values asynchronously: `ready` = 1, `result_valid` = 0, `result` = 0.
  - No pulse is produced.
  - A fresh App. B job afterwards completes correctly.
